// File: rtl/ledpat_pkg.sv
// ledpat_pkg: shared definitions for the LED pattern generator.
//   - channel mode encodings (mode_e) and their width MODE_W
//   - width helpers for the channel-select and mode-argument fields
//   - default_tap(): reset BLINK tap of a channel (counter MSBs on LEDs)
package ledpat_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_STATIC  = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_PWM     = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    // Channel-select width, never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Mode argument must hold both a PWM duty and a counter bit index.
    function automatic int unsigned val_width(input int unsigned width,
                                              input int unsigned pwm_bits);
        int unsigned tap_w;
        tap_w = $clog2(width);
        return (pwm_bits > tap_w) ? pwm_bits : tap_w;
    endfunction

    // Channel i blinks from counter bit WIDTH-1-i, clamped to bit 0.
    function automatic int unsigned default_tap(input int unsigned width,
                                                input int unsigned idx);
        return (idx >= width - 1) ? 0 : width - 1 - idx;
    endfunction

endpackage

// File: rtl/ledpat_if.sv
// ledpat_if: run-time configuration write port of ledpat_gen.
//   we   - write strobe, one cycle per write
//   ch   - target channel
//   mode - channel mode (mode_e encoding)
//   val  - mode argument (static level, blink tap or duty)
// master drives the port, slave (ledpat_gen) receives it.
interface ledpat_if
    import ledpat_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 26,
    parameter int unsigned PWM_BITS = 8
);
    localparam int unsigned CH_W  = ch_width(CHANNELS);
    localparam int unsigned VAL_W = val_width(WIDTH, PWM_BITS);

    logic              we;
    logic [CH_W-1:0]   ch;
    logic [MODE_W-1:0] mode;
    logic [VAL_W-1:0]  val;

    modport master (output we, output ch, output mode, output val);
    modport slave  (input we, input ch, input mode, input val);
endinterface

// File: rtl/ledpat_channel.sv
// ledpat_channel: one LED output channel.
//   i_clk/i_rst  - clock, asynchronous active-high reset
//   i_count      - free-running counter value
//   i_we/i_mode/i_val - decoded config write for this channel
//   i_tick       - PWM period boundary (low counter bits advance to 0)
//   o_led        - registered LED drive
// Build option LEDPAT_SYNC_UPDATE_EN: writes are held in a shadow register
// and only reach the active config on i_tick, so PWM periods never glitch.
// Without it a write becomes active on the next edge.
module ledpat_channel
    import ledpat_pkg::*;
#(
    parameter int unsigned WIDTH    = 26,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned VAL_W    = 8,
    parameter int unsigned INDEX    = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [WIDTH-1:0]  i_count,
    input  logic              i_we,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [VAL_W-1:0]  i_val,
    input  logic              i_tick,
    output logic              o_led
);
    localparam logic [VAL_W-1:0] TAP_MAX = VAL_W'(WIDTH - 1);
    localparam logic [VAL_W-1:0] TAP_RST = VAL_W'(default_tap(WIDTH, INDEX));

    mode_e            r_mode;
    logic [VAL_W-1:0] r_val;
    logic             r_led;

`ifdef LEDPAT_SYNC_UPDATE_EN
    mode_e            r_sh_mode;
    logic [VAL_W-1:0] r_sh_val;
    logic             r_pend;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mode    <= MODE_BLINK;
            r_val     <= TAP_RST;
            r_sh_mode <= MODE_BLINK;
            r_sh_val  <= '0;
            r_pend    <= 1'b0;
        end else if (i_tick && i_we) begin
            // Write landing on the boundary goes straight to the active set.
            r_mode <= mode_e'(i_mode);
            r_val  <= i_val;
            r_pend <= 1'b0;
        end else if (i_tick && r_pend) begin
            r_mode <= r_sh_mode;
            r_val  <= r_sh_val;
            r_pend <= 1'b0;
        end else if (i_we) begin
            r_sh_mode <= mode_e'(i_mode);
            r_sh_val  <= i_val;
            r_pend    <= 1'b1;
        end
    end
`else
    logic w_unused_tick;
    assign w_unused_tick = i_tick;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mode <= MODE_BLINK;
            r_val  <= TAP_RST;
        end else if (i_we) begin
            r_mode <= mode_e'(i_mode);
            r_val  <= i_val;
        end
    end
`endif

    logic [VAL_W-1:0]    w_tap;
    logic [WIDTH-1:0]    w_shift;
    logic [PWM_BITS:0]   w_phase;
    logic [PWM_BITS-1:0] w_duty;
    logic                w_led;

    assign w_tap   = (r_val > TAP_MAX) ? TAP_MAX : r_val;
    // Shift instead of a variable index keeps the tap select width-agnostic.
    assign w_shift = i_count >> w_tap;
    // Top PWM_BITS+1 counter bits: MSB picks ramp direction (triangle).
    assign w_phase = i_count[WIDTH-1 -: PWM_BITS+1];
    assign w_duty  = w_phase[PWM_BITS] ? ~w_phase[PWM_BITS-1:0] : w_phase[PWM_BITS-1:0];

    always_comb begin
        w_led = 1'b0;
        unique case (r_mode)
            MODE_STATIC:  w_led = r_val[0];
            MODE_BLINK:   w_led = w_shift[0];
            MODE_PWM:     w_led = (i_count[PWM_BITS-1:0] < r_val[PWM_BITS-1:0]);
            MODE_BREATHE: w_led = (i_count[PWM_BITS-1:0] < w_duty);
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_led;
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/ledpat_gen.sv
// ledpat_gen: free-running counter driving CHANNELS configurable LEDs
// (static, blink, PWM, breathe). Reset defaults blink counter MSBs.
//   i_clk   - board clock, rising edge
//   i_rst   - asynchronous active-high reset
//   i_en    - counter advance enable
//   cfg_if  - config write port (ledpat_if.slave)
//   o_count - current counter value
//   o_wrap  - one-cycle pulse when the counter increments to 0
//   o_led   - registered LED drive
// Build option LEDPAT_SYNC_UPDATE_EN: config writes apply at PWM period
// boundaries instead of on the next edge (see ledpat_channel).
module ledpat_gen
    import ledpat_pkg::*;
#(
    parameter int unsigned WIDTH    = 26,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    ledpat_if.slave             cfg_if,
    output logic [WIDTH-1:0]    o_count,
    output logic                o_wrap,
    output logic [CHANNELS-1:0] o_led
);
    localparam int unsigned CH_W  = ch_width(CHANNELS);
    localparam int unsigned VAL_W = val_width(WIDTH, PWM_BITS);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             w_tick;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= i_en && (r_count == '1);
            if (i_en) begin
                r_count <= r_count + WIDTH'(1);
            end
        end
    end

    // Low PWM bits advance to 0 on this edge: start of a new PWM period.
    assign w_tick = i_en && (r_count[PWM_BITS-1:0] == '1);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic w_we;
        // Only indices below CHANNELS decode, so out-of-range writes drop.
        assign w_we = cfg_if.we && (cfg_if.ch == CH_W'(g));

        ledpat_channel #(
            .WIDTH   (WIDTH),
            .PWM_BITS(PWM_BITS),
            .VAL_W   (VAL_W),
            .INDEX   (g)
        ) u_channel (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_count(r_count),
            .i_we   (w_we),
            .i_mode (cfg_if.mode),
            .i_val  (cfg_if.val),
            .i_tick (w_tick),
            .o_led  (o_led[g])
        );
    end

    assign o_count = r_count;
    assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_ledpat_gen.sv
// tb_ledpat_gen: directed self-checking bench for ledpat_gen
// (WIDTH=8, CHANNELS=3, PWM_BITS=4). Honours LEDPAT_SYNC_UPDATE_EN.
module tb_ledpat_gen;
    import ledpat_pkg::*;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 3;
    localparam int unsigned PWM_BITS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] count;
    logic       wrap;
    logic [2:0] led;

    ledpat_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .PWM_BITS(PWM_BITS)) cfg_if ();

    ledpat_gen #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PWM_BITS(PWM_BITS)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (en),
        .cfg_if (cfg_if),
        .o_count(count),
        .o_wrap (wrap),
        .o_led  (led)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_cnt    = 8'h00;
    logic [7:0] prev;
    int         on;
    int         exp_br[16] = '{0, 2, 4, 6, 9, 11, 13, 15, 14, 12, 10, 8, 7, 5, 3, 1};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (model count 0x%0h)", tag, act, exp, m_cnt);
        end
    endtask

    task automatic step();
        logic adv;
        adv = en && !rst;
        @(posedge clk);
        #1;
        if (rst) m_cnt = 8'h00;
        else if (adv) m_cnt = m_cnt + 8'h01;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input mode_e mode, input logic [3:0] val);
        cfg_if.we   = 1'b1;
        cfg_if.ch   = ch;
        cfg_if.mode = mode;
        cfg_if.val  = val;
        step();
        cfg_if.we = 1'b0;
    endtask

    // Step until LED reflects the first count of a PWM period.
    task automatic align();
        do step(); while (m_cnt[3:0] != 4'd1);
    endtask

    task automatic step_to(input logic [7:0] target);
        while (m_cnt != target) step();
    endtask

    task automatic measure(input int c, output int n_on);
        n_on = 0;
        repeat (16) begin
            n_on += int'(led[c]);
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_if.we = 1'b0; cfg_if.ch = '0; cfg_if.mode = '0; cfg_if.val = '0;
        step();
        step();
        check_eq("rst_count", count, 8'h00);
        check_eq("rst_wrap", wrap, 0);
        check_eq("rst_led", led, 3'b000);
        en  = 1'b1;
        rst = 1'b0;

        // Defaults: LED i follows COUNT[7-i] one cycle late; wrap on 0.
        repeat (300) begin
            prev = m_cnt;
            step();
            check_eq("cnt", count, m_cnt);
            check_eq("wrap", wrap, (m_cnt == 8'h00));
            check_eq("dflt_led0", led[0], prev[7]);
            check_eq("dflt_led1", led[1], prev[6]);
            check_eq("dflt_led2", led[2], prev[5]);
        end

        // PWM duties.
        cfg_write(2'd0, MODE_PWM, 4'd4);
        align();
        measure(0, on); check_eq("pwm4", on, 4);
        cfg_write(2'd0, MODE_PWM, 4'd0);
        align();
        measure(0, on); check_eq("pwm0", on, 0);
        cfg_write(2'd0, MODE_PWM, 4'd15);
        align();
        measure(0, on); check_eq("pwm15", on, 15);

        // Breathe: on-count per 16-cycle period over one 256-cycle ramp.
        cfg_write(2'd0, MODE_BREATHE, 4'd0);
        align();
        step_to(8'h01);
        for (int k = 0; k < 16; k++) begin
            measure(0, on);
            check_eq($sformatf("breathe_p%0d", k), on, exp_br[k]);
        end

        // Hold with EN=0 at 0x37.
        cfg_write(2'd0, MODE_PWM, 4'd8);
        align();
        step_to(8'h37);
        en = 1'b0;
        repeat (50) begin
            step();
            check_eq("hold_cnt", count, 8'h37);
            check_eq("hold_wrap", wrap, 0);
            check_eq("hold_led", led, 3'b101);
        end
        en = 1'b1;
        step();
        check_eq("resume_cnt", count, 8'h38);
        check_eq("resume_led_a", led, 3'b101);
        step();
        check_eq("resume_led_b", led, 3'b100);

        // Hold right after a wrap: pulse must not stretch.
        step_to(8'h00);
        check_eq("wrap_at0", wrap, 1);
        en = 1'b0;
        step();
        check_eq("hold0_wrap", wrap, 0);
        check_eq("hold0_cnt", count, 8'h00);
        en = 1'b1;

        // BLINK tap beyond WIDTH-1 clamps to bit 7.
        cfg_write(2'd1, MODE_BLINK, 4'd15);
        align();
        step_to(8'h41); check_eq("clamp_41", led[1], 0);
        step_to(8'h81); check_eq("clamp_81", led[1], 1);

        // Out-of-range channel write is dropped.
        cfg_write(2'd3, MODE_STATIC, 4'd1);
        align();
        step_to(8'h01);
        check_eq("oor_led1", led[1], 0);
        measure(0, on); check_eq("oor_pwm8", on, 8);
        step_to(8'h21); check_eq("oor_led2", led[2], 1);
        step_to(8'h81); check_eq("oor_led1b", led[1], 1);

        // Write-to-active latency: PWM 8 written at nibble 5.
        cfg_write(2'd0, MODE_STATIC, 4'd0);
        align();
        while (m_cnt[3:0] != 4'd5) step();
        cfg_write(2'd0, MODE_PWM, 4'd8);
        check_eq("lat_old", led[0], 0);
`ifdef LEDPAT_SYNC_UPDATE_EN
        while (m_cnt[3:0] != 4'd1) begin
            check_eq("lat_pending", led[0], 0);
            step();
        end
        check_eq("lat_new", led[0], 1);
`else
        step();
        check_eq("lat_new", led[0], 1);
`endif

        // Write coinciding with wrap.
        step_to(8'hFF);
        cfg_write(2'd0, MODE_STATIC, 4'd1);
        check_eq("ww_wrap", wrap, 1);
        check_eq("ww_led_old", led[0], 0);
        step();
        check_eq("ww_led_new", led[0], 1);
        check_eq("ww_wrap_off", wrap, 0);

        // Asynchronous reset mid-run, with a write just before it.
        step_to(8'h92);
        cfg_write(2'd1, MODE_STATIC, 4'd1);
        check_eq("pre_rst_cnt", count, 8'h93);
        #2;
        rst   = 1'b1;
        m_cnt = 8'h00;
        #1;
        check_eq("arst_cnt", count, 8'h00);
        check_eq("arst_wrap", wrap, 0);
        check_eq("arst_led", led, 3'b000);
        step();
        check_eq("arst_hold", count, 8'h00);
        rst = 1'b0;
        step_to(8'h41); check_eq("post_rst_41", led, 3'b010);
        step_to(8'h81); check_eq("post_rst_81", led, 3'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
